// File: rtl/maszyna_w_control_if.sv
// Host/core handshake bundle for the Maszyna W control unit.
// master = host + core side, slave = control unit.
interface maszyna_w_control_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int KOD_WIDTH     = WORD_WIDTH - ADDRESS_WIDTH,
  parameter int CNT_WIDTH     = 16
);
  logic                 start;
  logic                 stop;
  logic                 step_mode;
  logic                 hold;
  logic [KOD_WIDTH-1:0] KOD;
  logic                 ZF;
  logic                 ZAK;
  logic [31:0]          signal_errors;
  logic [31:0]          signals;
  logic                 busy;
  logic                 halted;
  logic                 illegal;
  logic                 fault;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    output start, stop, step_mode, hold, KOD, ZF, ZAK, signal_errors,
    input  signals, busy, halted, illegal, fault, instr_count
  );

  modport slave (
    input  start, stop, step_mode, hold, KOD, ZF, ZAK, signal_errors,
    output signals, busy, halted, illegal, fault, instr_count
  );
endinterface

// File: rtl/maszyna_w_control.sv
// Microprogrammed control unit for the Maszyna W core: one control word per
// beat (F1, F2, DEC, E1[, E2]), with start/stop/step/hold host control.
module maszyna_w_control #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int KOD_WIDTH     = WORD_WIDTH - ADDRESS_WIDTH,
  parameter int CNT_WIDTH     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  maszyna_w_control_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_F1   = 3'd1;
  localparam logic [2:0] S_F2   = 3'd2;
  localparam logic [2:0] S_DEC  = 3'd3;
  localparam logic [2:0] S_E1   = 3'd4;
  localparam logic [2:0] S_E2   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  // Control words (bit map: wyak 0 .. przep 15)
  localparam logic [15:0] W_FETCH = 16'h1000; // czyt
  localparam logic [15:0] W_IR    = 16'h0460; // wys|wei|il
  localparam logic [15:0] W_DEC   = 16'h0210; // wyad|wea
  localparam logic [15:0] W_NEXT  = 16'h0280; // wyl|wea : A <- L, i.e. fall through
  localparam logic [15:0] W_JUMP  = 16'h0310; // wyad|wel|wea : L <- addr, A <- addr
  localparam logic [15:0] W_DOD   = 16'h468A;
  localparam logic [15:0] W_ODE   = 16'h4686;
  localparam logic [15:0] W_POB   = 16'hC682;
  localparam logic [15:0] W_LAD1  = 16'h0801; // wyak|wes
  localparam logic [15:0] W_LAD2  = 16'h2280; // pisz|wyl|wea

  logic [2:0]           state;
  logic                 stop_req;
  logic                 illegal_q;
  logic                 fault_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic        busy;
  logic        op_ok;
  logic [2:0]  op;
  logic        halt_op;
  logic        two_beat;
  logic        last_beat;
  logic        pause;
  logic [15:0] sig;

  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign op_ok     = bus.KOD < KOD_WIDTH'(8);
  assign op        = bus.KOD[2:0];
  assign halt_op   = !op_ok || (op == 3'd0);
  assign two_beat  = op_ok && (op inside {3'd1, 3'd2, 3'd3, 3'd6});
  assign last_beat = ((state == S_E1) && !two_beat) || (state == S_E2);
  assign pause     = bus.step_mode || stop_req;

  // Control word for the current beat; zero when idle, halted or held.
  always_comb begin
    sig = '0;
    if (!bus.hold) begin
      case (state)
        S_F1:  sig = W_FETCH;
        S_F2:  sig = W_IR;
        S_DEC: sig = W_DEC;
        S_E1: begin
          if (!op_ok) sig = W_NEXT;
          else begin
            case (op)
              3'd0:                sig = W_NEXT;
              3'd1, 3'd2, 3'd3:    sig = W_FETCH;
              3'd4:                sig = W_JUMP;
              3'd5:                sig = bus.ZF  ? W_JUMP : W_NEXT;
              3'd6:                sig = W_LAD1;
              default:             sig = bus.ZAK ? W_JUMP : W_NEXT;
            endcase
          end
        end
        S_E2: begin
          case (op)
            3'd1:    sig = W_DOD;
            3'd2:    sig = W_ODE;
            3'd3:    sig = W_POB;
            3'd6:    sig = W_LAD2;
            default: sig = '0;
          endcase
        end
        default: sig = '0;
      endcase
    end
  end

  // Beat sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else if (!bus.hold) begin
      case (state)
        S_IDLE, S_HALT: if (bus.start) state <= S_F1;
        S_F1:           state <= S_F2;
        S_F2:           state <= S_DEC;
        S_DEC:          state <= S_E1;
        S_E1, S_E2: begin
          if (!last_beat)   state <= S_E2;
          else if (halt_op) state <= S_HALT;
          else if (pause)   state <= S_IDLE;
          else              state <= S_F1;
        end
        default:        state <= S_IDLE;
      endcase
    end
  end

  // Stop request latch: consumed whenever an instruction boundary pauses the
  // machine (IDLE or HALT); a stop pulsed together with start in IDLE is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stop_req <= 1'b0;
    else if (!bus.hold) begin
      if (busy) begin
        if (last_beat && (halt_op || pause)) stop_req <= 1'b0;
        else if (bus.stop)                   stop_req <= 1'b1;
      end else if (state == S_IDLE && bus.start && bus.stop) begin
        stop_req <= 1'b1;
      end
    end
  end

  // Completed-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else if (!bus.hold && last_beat) cnt_q <= cnt_q + 1'b1;
  end

  // Sticky illegal (cleared by start) and fault (cleared only by reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else if (!bus.hold) begin
      if (!busy && bus.start)                    illegal_q <= 1'b0;
      else if (last_beat && !op_ok)              illegal_q <= 1'b1;
      if (busy && (bus.signal_errors != 32'd0))  fault_q   <= 1'b1;
    end
  end

  assign bus.signals     = {16'h0000, sig};
  assign bus.busy        = busy;
  assign bus.halted      = (state == S_HALT);
  assign bus.illegal     = illegal_q;
  assign bus.fault       = fault_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_maszyna_w_control.sv
// Bench for maszyna_w_control: directed handshake scenarios plus random
// start/stop/step/hold/opcode traffic against a beat-list reference model.
module tb_maszyna_w_control;
  localparam int KW = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  maszyna_w_control_if bus ();
  maszyna_w_control dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: machine is either paused (idle/halted) or working
  // through a list of remaining control words for the current instruction.
  int unsigned  m_kod;
  bit           m_zf, m_zak;
  bit           m_busy, m_halt, m_ill, m_fault, m_stop;
  int unsigned  m_cnt;
  logic [31:0]  q[$];
  int           kod_force = -1;
  logic [31:0]  sig_seen;

  function automatic void new_instr();
    int unsigned r;
    if (kod_force >= 0) m_kod = kod_force;
    else begin
      r = $urandom_range(0, 39);
      if (r < 2)      m_kod = 0;
      else if (r < 3) m_kod = $urandom_range(8, 24'hFFFFFF);
      else            m_kod = (r % 7) + 1;
    end
    m_zf  = 1'($urandom);
    m_zak = 1'($urandom);
    q.delete();
    q.push_back(32'h1000);
    q.push_back(32'h0460);
    q.push_back(32'h0210);
    case (m_kod)
      1: begin q.push_back(32'h1000); q.push_back(32'h468A); end
      2: begin q.push_back(32'h1000); q.push_back(32'h4686); end
      3: begin q.push_back(32'h1000); q.push_back(32'hC682); end
      4: q.push_back(32'h0310);
      5: q.push_back(m_zf  ? 32'h0310 : 32'h0280);
      6: begin q.push_back(32'h0801); q.push_back(32'h2280); end
      7: q.push_back(m_zak ? 32'h0310 : 32'h0280);
      default: q.push_back(32'h0280);
    endcase
  endfunction

  // One clock: drive inputs, check outputs against model, advance model.
  task automatic cycle(input bit st, input bit sp, input bit sm, input bit hd,
                       input logic [31:0] se);
    logic [31:0] exp_sig;
    @(negedge clk);
    bus.start = st; bus.stop = sp; bus.step_mode = sm; bus.hold = hd;
    bus.signal_errors = se;
    bus.KOD = KW'(m_kod); bus.ZF = m_zf; bus.ZAK = m_zak;
    #1;
    exp_sig = 32'd0;
    if (!hd && m_busy) exp_sig = q[0];
    sig_seen = bus.signals;
    chk("signals", 64'(bus.signals), 64'(exp_sig));
    chk("busy",    64'(bus.busy),    64'(m_busy));
    chk("halted",  64'(bus.halted),  64'(m_halt));
    chk("illegal", 64'(bus.illegal), 64'(m_ill));
    chk("fault",   64'(bus.fault),   64'(m_fault));
    chk("count",   64'(bus.instr_count), 64'(m_cnt[15:0]));
    if (!hd) begin
      if (m_busy) begin
        if (se != 32'd0) m_fault = 1'b1;
        if (q.size() == 1) begin
          m_cnt++;
          if (m_kod == 0 || m_kod > 7) begin
            m_busy = 1'b0; m_halt = 1'b1; m_ill = (m_kod > 7); m_stop = 1'b0;
          end else if (sm || m_stop) begin
            m_busy = 1'b0; m_stop = 1'b0;
          end else begin
            if (sp) m_stop = 1'b1;
            new_instr();
          end
        end else begin
          void'(q.pop_front());
          if (sp) m_stop = 1'b1;
        end
      end else if (st) begin
        if (!m_halt && sp) m_stop = 1'b1;
        m_busy = 1'b1; m_halt = 1'b0; m_ill = 1'b0;
        new_instr();
      end
    end
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.step_mode = 1'b0;
    bus.signal_errors = 32'd0;
    reset_n = 1'b0;
    #1;
    chk("rst_signals", 64'(bus.signals),     64'd0);
    chk("rst_busy",    64'(bus.busy),        64'd0);
    chk("rst_count",   64'(bus.instr_count), 64'd0);
    chk("rst_halted",  64'(bus.halted),      64'd0);
    chk("rst_illegal", 64'(bus.illegal),     64'd0);
    chk("rst_fault",   64'(bus.fault),       64'd0);
    m_busy = 0; m_halt = 0; m_ill = 0; m_fault = 0; m_stop = 0; m_cnt = 0;
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [31:0] dod_tr [5];

  initial begin
    bus.start = 0; bus.stop = 0; bus.step_mode = 0; bus.hold = 0;
    bus.KOD = '0; bus.ZF = 0; bus.ZAK = 0; bus.signal_errors = '0;
    m_kod = 0; m_zf = 0; m_zak = 0;
    do_reset();
    idle_cycle();

    // DOD beat trace, then reset in E1 of the following DOD
    dod_tr = '{32'h1000, 32'h0460, 32'h0210, 32'h1000, 32'h468A};
    kod_force = 1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      chk("dod_trace", 64'(sig_seen), 64'(dod_tr[i]));
    end
    for (int i = 0; i < 3; i++) idle_cycle();
    do_reset();
    idle_cycle();
    chk("idle_after_rst", 64'(bus.busy), 64'd0);

    // Illegal opcode halts after 4 beats; restart clears illegal
    kod_force = 9;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) idle_cycle();
    idle_cycle();
    chk("ill_halted", 64'(bus.halted), 64'd1);
    chk("ill_flag",   64'(bus.illegal), 64'd1);
    kod_force = 4;
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    idle_cycle();
    chk("ill_cleared", 64'(bus.illegal), 64'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("step_idle", 64'(bus.busy), 64'd0);

    // Hold three cycles in E1 of a DOD
    kod_force = 1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) idle_cycle();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
    idle_cycle();
    chk("hold_resume", 64'(sig_seen), 64'h1000);

    // Stop in F2 of the next instruction, then start+stop together in IDLE
    idle_cycle();
    idle_cycle();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) idle_cycle();
    idle_cycle();
    chk("stop_idle", 64'(bus.busy), 64'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) idle_cycle();
    chk("startstop_idle", 64'(bus.busy), 64'd0);

    // Randomized traffic
    kod_force = -1;
    begin
      bit sm;
      sm = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit st, sp, hd;
        logic [31:0] se;
        if (i % 700 == 699) do_reset();
        if ($urandom_range(0, 99) == 0) sm = ~sm;
        st = m_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
        sp = ($urandom_range(0, 19) == 0);
        hd = ($urandom_range(0, 7) == 0);
        se = ($urandom_range(0, 199) == 0) ? 32'($urandom) | 32'd1 : 32'd0;
        cycle(st, sp, sm, hd, se);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
